// File: rtl/mini_cpu_pkg.sv
// Shared constants and types for the mini-CPU LCD display responder.
package mini_cpu_pkg;

  localparam logic [2:0] OP_LOAD    = 3'd0;
  localparam logic [2:0] OP_ADD     = 3'd1;
  localparam logic [2:0] OP_ADDI    = 3'd2;
  localparam logic [2:0] OP_SUB     = 3'd3;
  localparam logic [2:0] OP_SUBI    = 3'd4;
  localparam logic [2:0] OP_MUL     = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd6;
  localparam logic [2:0] OP_DISPLAY = 3'd7;

  localparam logic [7:0] CMD_FUNC    = 8'h38;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_LINE1   = 8'h80;
  localparam logic [7:0] CMD_LINE2   = 8'hC0;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int NUM_INIT_CMDS = 4;
  localparam int NUM_WRITES    = 34;

  typedef enum logic [2:0] {
    INIT_WAIT, INIT_CMD, IDLE, CONVERT, WRITE_SETUP, WRITE_EN, WRITE_HOLD
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_wr_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return CMD_FUNC;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_display_ctrl_if.sv
// CPU-to-display request channel: valid/ready handshake carrying opcode and result.
interface lcd_display_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  opcode;
  logic [15:0] result;

  modport master (output req_valid, output opcode, output result, input req_ready);
  modport slave  (input req_valid, input opcode, input result, output req_ready);
endinterface

// File: rtl/lcd_display_ctrl_bin2bcd.sv
// Sequential double-dabble: 17-bit unsigned to 5 BCD digits in 17 shift cycles.
module bin16_to_bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [16:0] bin_i,
  output logic        done_o,
  output logic [19:0] bcd_o
);
  logic [16:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d, adj;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d;

  // add-3 correction per digit before each shift
  for (genvar g = 0; g < 5; g++) begin : g_adj
    assign adj[g*4 +: 4] = (bcd_q[g*4 +: 4] >= 4'd5) ? bcd_q[g*4 +: 4] + 4'd3
                                                      : bcd_q[g*4 +: 4];
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      bin_d  = bin_i;
      bcd_d  = '0;
      cnt_d  = 5'd17;
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/lcd_display_ctrl.sv
// HD44780 16x2 driver: shows the opcode mnemonic on line 1 and the signed result on line 2.
module lcd_display_ctrl
  import mini_cpu_pkg::*;
#(
  parameter int INIT_WAIT_CYCLES  = 750000,
  parameter int EN_CYCLES         = 25,
  parameter int WAIT_CYCLES       = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  lcd_display_ctrl_if.slave req,
  output logic [7:0]        lcd_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_en,
  output logic              lcd_on,
  output logic              lcd_blon
);
  lcd_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d, hold_len;
  logic [5:0]  idx_q, idx_d;
  logic        init_q, init_d;
  logic        started_q, started_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] res_q, res_d;
  lcd_wr_t     wr_q, wr_d;
  logic        en_q;
  logic        bcd_start, bcd_done;
  logic [19:0] bcd_digits;
  logic [16:0] mag;

  // 17-bit negate so that -32768 yields +32768
  assign mag = res_q[15] ? (17'd0 - {res_q[15], res_q}) : {1'b0, res_q};

  bin16_to_bcd u_bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (bcd_start),
    .bin_i   (mag),
    .done_o  (bcd_done),
    .bcd_o   (bcd_digits)
  );

  function automatic logic [7:0] mnem_char(input logic [2:0] op, input logic [3:0] pos);
    logic [63:0] s;
    int          p;
    case (op)
      OP_LOAD:  s = "LOAD    ";
      OP_ADD:   s = "ADD     ";
      OP_ADDI:  s = "ADDI    ";
      OP_SUB:   s = "SUB     ";
      OP_SUBI:  s = "SUBI    ";
      OP_MUL:   s = "MUL     ";
      OP_CLEAR: s = "CLEAR   ";
      default:  s = "DISPLAY ";
    endcase
    p = 7 - int'(pos);
    if (pos > 4'd7) return ASCII_SPACE;
    return s[p*8 +: 8];
  endfunction

  // byte i (0..33) of the display refresh sequence
  function automatic lcd_wr_t disp_byte(input logic [5:0] i, input logic [2:0] op,
                                        input logic neg, input logic [19:0] bcd);
    lcd_wr_t w;
    int      d;
    w.rs   = 1'b1;
    w.data = ASCII_SPACE;
    d      = 23 - int'(i);
    if (i == 6'd0) begin
      w.rs   = 1'b0;
      w.data = CMD_LINE1;
    end else if (i <= 6'd16) begin
      w.data = mnem_char(op, 4'(i - 6'd1));
    end else if (i == 6'd17) begin
      w.rs   = 1'b0;
      w.data = CMD_LINE2;
    end else if (i == 6'd18) begin
      w.data = neg ? ASCII_MINUS : ASCII_PLUS;
    end else if (i <= 6'd23) begin
      w.data = ASCII_ZERO + {4'h0, bcd[d*4 +: 4]};
    end
    return w;
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    init_d        = init_q;
    started_d     = started_q;
    op_d          = op_q;
    res_d         = res_q;
    wr_d          = wr_q;
    bcd_start     = 1'b0;
    req.req_ready = 1'b0;
    hold_len      = (!wr_q.rs && wr_q.data == CMD_CLEAR) ? 32'(CLEAR_WAIT_CYCLES)
                                                         : 32'(WAIT_CYCLES);
    case (state_q)
      INIT_WAIT: begin
        if (cnt_q == 32'(INIT_WAIT_CYCLES - 1)) begin
          state_d = INIT_CMD;
          cnt_d   = '0;
          idx_d   = '0;
          init_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      INIT_CMD: begin
        wr_d.rs   = 1'b0;
        wr_d.data = init_cmd(idx_q[1:0]);
        state_d   = WRITE_SETUP;
      end
      IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid) begin
          op_d      = req.opcode;
          res_d     = req.result;
          started_d = 1'b0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        if (!started_q) begin
          bcd_start = 1'b1;
          started_d = 1'b1;
        end else if (bcd_done) begin
          idx_d   = '0;
          wr_d    = disp_byte(6'd0, op_q, res_q[15], bcd_digits);
          state_d = WRITE_SETUP;
        end
      end
      WRITE_SETUP: begin
        cnt_d   = '0;
        state_d = WRITE_EN;
      end
      WRITE_EN: begin
        if (cnt_q == 32'(EN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = WRITE_HOLD;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WRITE_HOLD: begin
        if (cnt_q == hold_len - 32'd1) begin
          cnt_d = '0;
          if (init_q) begin
            if (idx_q == 6'(NUM_INIT_CMDS - 1)) begin
              init_d  = 1'b0;
              state_d = IDLE;
            end else begin
              idx_d   = idx_q + 6'd1;
              state_d = INIT_CMD;
            end
          end else if (idx_q == 6'(NUM_WRITES - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 6'd1;
            wr_d    = disp_byte(idx_q + 6'd1, op_q, res_q[15], bcd_digits);
            state_d = WRITE_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT_WAIT;
      cnt_q     <= '0;
      idx_q     <= '0;
      init_q    <= 1'b0;
      started_q <= 1'b0;
      op_q      <= '0;
      res_q     <= '0;
      wr_q      <= '0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      init_q    <= init_d;
      started_q <= started_d;
      op_q      <= op_d;
      res_q     <= res_d;
      wr_q      <= wr_d;
      en_q      <= (state_d == WRITE_EN);
    end
  end

  assign lcd_data = wr_q.data;
  assign lcd_rs   = wr_q.rs;
  assign lcd_en   = en_q;
  assign lcd_rw   = 1'b0;
  assign lcd_on   = 1'b1;
  assign lcd_blon = 1'b1;
endmodule

// File: tb/tb_lcd_display_ctrl.sv
// Directed bench for lcd_display_ctrl with shortened LCD timing.
module tb_lcd_display_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;

  lcd_display_ctrl_if rif ();

  lcd_display_ctrl #(
    .INIT_WAIT_CYCLES (10),
    .EN_CYCLES        (2),
    .WAIT_CYCLES      (4),
    .CLEAR_WAIT_CYCLES(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (rif.slave),
    .lcd_data(lcd_data),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_en  (lcd_en),
    .lcd_on  (lcd_on),
    .lcd_blon(lcd_blon)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs;
    int data;
    int width;
    int gap;
  } rec_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] res;
    string       l1;
    string       l2;
  } vec_t;

  rec_t wq[$];
  rec_t cur;
  int   total = 0;
  int   bad = 0;
  int   gap = 0;
  int   width = 0;
  int   inflight = 0;
  int   unstable = 0;

  // write monitor: one record per lcd_en pulse, plus low cycles preceding it
  always @(negedge clk) begin
    if (rst) begin
      inflight = 0;
      gap      = 0;
      width    = 0;
    end else if (lcd_en) begin
      if (inflight == 0) begin
        inflight = 1;
        cur.rs   = int'(lcd_rs);
        cur.data = int'(lcd_data);
        cur.gap  = gap;
        width    = 0;
      end else if (cur.rs != int'(lcd_rs) || cur.data != int'(lcd_data)) begin
        unstable++;
      end
      width++;
    end else begin
      if (inflight != 0) begin
        cur.width = width;
        wq.push_back(cur);
        inflight = 0;
        gap      = 0;
      end
      gap++;
    end
  end

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int ch(input string s, input int i);
    if (i < s.len()) return int'(s[i]);
    return 32'h20;
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [15:0] res,
                              input string l1, input string l2);
    vec_t v;
    v.op  = op;
    v.res = res;
    v.l1  = l1;
    v.l2  = l2;
    return v;
  endfunction

  task automatic wait_ready();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!rif.req_ready && c < 2000);
    if (!rif.req_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic collect(input int n);
    int c;
    c = 0;
    while (wq.size() < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("write_count", wq.size(), n);
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] res);
    wait_ready();
    rif.req_valid = 1'b1;
    rif.opcode    = op;
    rif.result    = res;
    @(posedge clk);
    #1 rif.req_valid = 1'b0;
  endtask

  // called #1 after the last reset edge
  task automatic init_check();
    int c;
    int exp_d[4] = '{32'h38, 32'h0C, 32'h01, 32'h06};
    int exp_g[4] = '{12, 6, 6, 10};
    c = -1;
    do begin
      @(negedge clk);
      c++;
    end while (!rif.req_ready && c < 300);
    chk("init_ready_cycle", c, 46);
    chk("init_write_count", wq.size(), 4);
    for (int k = 0; k < 4 && k < wq.size(); k++) begin
      chk($sformatf("init%0d_data", k), wq[k].data, exp_d[k]);
      chk($sformatf("init%0d_rs", k), wq[k].rs, 0);
      chk($sformatf("init%0d_en_width", k), wq[k].width, 2);
      chk($sformatf("init%0d_gap", k), wq[k].gap, exp_g[k]);
    end
  endtask

  task automatic check_seq(input vec_t v, input int base, input string tag);
    int exp;
    int act;
    int werr;
    int gerr;
    werr = 0;
    gerr = 0;
    for (int k = 0; k < 34; k++) begin
      if (k == 0)       exp = 32'h080;
      else if (k <= 16) exp = 32'h100 | ch(v.l1, k - 1);
      else if (k == 17) exp = 32'h0C0;
      else              exp = 32'h100 | ch(v.l2, k - 18);
      act = (wq[base+k].rs << 8) | wq[base+k].data;
      chk($sformatf("%s_w%0d", tag, k), act, exp);
      if (wq[base+k].width != 2) werr++;
      if (k > 0 && wq[base+k].gap != 5) gerr++;
    end
    chk({tag, "_en_width_errs"}, werr, 0);
    chk({tag, "_7cycle_spacing_errs"}, gerr, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int xfers;
    int c;
    vecs[0] = mk(3'd1, 16'd1234, "ADD", "+01234");
    vecs[1] = mk(3'd3, 16'hFFFF, "SUB", "-00001");
    vecs[2] = mk(3'd5, 16'h8000, "MUL", "-32768");
    vecs[3] = mk(3'd7, 16'h7FFF, "DISPLAY", "+32767");
    vecs[4] = mk(3'd0, 16'd0,    "LOAD", "+00000");
    vecs[5] = mk(3'd2, 16'hFFF6, "ADDI", "-00010");
    vecs[6] = mk(3'd4, 16'd100,  "SUBI", "+00100");
    vecs[7] = mk(3'd6, 16'd99,   "CLEAR", "+00099");

    rst           = 1'b1;
    rif.req_valid = 1'b0;
    rif.opcode    = '0;
    rif.result    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(rif.req_ready), 0);
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_rw", int'(lcd_rw), 0);
    chk("rst_data", int'(lcd_data), 0);
    chk("rst_on", int'(lcd_on), 1);
    chk("rst_blon", int'(lcd_blon), 1);
    rst = 1'b0;
    wq.delete();
    init_check();

    for (int v = 0; v < 8; v++) begin
      wq.delete();
      send(vecs[v].op, vecs[v].res);
      collect(34);
      if (wq.size() >= 34) check_seq(vecs[v], 0, $sformatf("vec%0d", v));
    end

    // request held valid across two full refreshes: one transfer per ready window
    wait_ready();
    wq.delete();
    rif.req_valid = 1'b1;
    rif.opcode    = 3'd2;
    rif.result    = 16'd5;
    xfers = 1;
    c = 0;
    while (wq.size() < 68 && c < 3000) begin
      @(negedge clk);
      c++;
      if (rif.req_valid && rif.req_ready) xfers++;
    end
    rif.req_valid = 1'b0;
    chk("busy_transfers", xfers, 2);
    chk("busy_write_count", wq.size(), 68);
    if (wq.size() >= 68) begin
      check_seq(mk(3'd2, 16'd5, "ADDI", "+00005"), 0, "busy_a");
      check_seq(mk(3'd2, 16'd5, "ADDI", "+00005"), 34, "busy_b");
    end
    wait_ready();

    // reset while lcd_en is high
    send(3'd1, 16'd1234);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!lcd_en && c < 200);
    chk("midrst_saw_en", int'(lcd_en), 1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_en", int'(lcd_en), 0);
    chk("midrst_ready", int'(rif.req_ready), 0);
    chk("midrst_rs", int'(lcd_rs), 0);
    chk("midrst_data", int'(lcd_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wq.delete();
    init_check();

    chk("data_stable_during_en", unstable, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_display_ctrl.md
Name: lcd_display_ctrl

Overview:
- Display-side responder for the mini-CPU. The CPU core issues one display request per executed instruction, carrying the opcode and the 16-bit result.
- This block accepts the request over a valid/ready handshake and converts the result to signed decimal.
- It drives a 16x2 HD44780-compatible LCD over an 8-bit parallel bus: line 1 shows the operation mnemonic, line 2 shows the signed result.

Parameters:
- INIT_WAIT_CYCLES, 750000: idle cycles after reset before the first LCD command (15 ms at 50 MHz).
- EN_CYCLES, 25: width of the lcd_en high pulse.
- WAIT_CYCLES, 2500: hold time after lcd_en falls for any write except clear.
- CLEAR_WAIT_CYCLES, 100000: hold time after lcd_en falls for the clear command 0x01.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  CPU has a display request
- req_ready  out  1  block can accept a request
- opcode  in  3  operation code (LOAD=0, ADD=1, ADDI=2, SUB=3, SUBI=4, MUL=5, CLEAR=6, DISPLAY=7)
- result  in  16  two's-complement result to show
- lcd_data  out  8  LCD data bus
- lcd_rs  out  1  0 = command, 1 = character
- lcd_rw  out  1  always 0 (write-only)
- lcd_en  out  1  LCD enable strobe
- lcd_on  out  1  LCD power, constant 1
- lcd_blon  out  1  backlight, constant 1

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: req_ready=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, lcd_on=1, lcd_blon=1.
- States: INIT_WAIT, INIT_CMD, IDLE, CONVERT, WRITE_SETUP, WRITE_EN, WRITE_HOLD.
- INIT_WAIT: count INIT_WAIT_CYCLES, then go to INIT_CMD.
- INIT_CMD issues, in order: 0x38 (function set), 0x0C (display on, cursor off), 0x01 (clear, uses CLEAR_WAIT_CYCLES), 0x06 (entry mode). Then go to IDLE.
- Write timing, every command or character:
  - WRITE_SETUP: exactly 1 cycle; lcd_rs and lcd_data valid, lcd_en=0.
  - WRITE_EN: exactly EN_CYCLES cycles with lcd_en=1.
  - WRITE_HOLD: WAIT_CYCLES cycles with lcd_en=0, or CLEAR_WAIT_CYCLES when the byte is command 0x01.
  - lcd_data and lcd_rs are stable from WRITE_SETUP through the end of WRITE_HOLD.
- IDLE: req_ready=1. A transfer occurs on a cycle where req_valid && req_ready.
  - On transfer: latch opcode and result; req_ready=0 on the next cycle; go to CONVERT.
  - req_valid while req_ready=0 is ignored; no queuing.
- CONVERT:
  - Compute magnitude |result| as 17-bit unsigned, so -32768 is handled correctly.
  - Sign char is '-' (0x2D) if result[15]=1, else '+' (0x2B).
  - Start bin16_to_bcd and wait for its done pulse, at most 18 cycles.
- Write sequence, 34 writes:
  - Command 0x80, then 16 line-1 chars.
  - Command 0xC0, then 16 line-2 chars.
- Line 1 mnemonics, left-justified and padded with spaces (0x20) to 16 chars: "LOAD", "ADD", "ADDI", "SUB", "SUBI", "MUL", "CLEAR", "DISPLAY".
- Line 2: sign, then 5 ASCII digits (0x30+BCD, leading zeros kept), then 10 spaces.
- After the last hold completes, return to IDLE; req_ready=1 on the following cycle.
- Reset mid-operation: on the cycle after rst is sampled high, all outputs take their reset values (lcd_en drops immediately) and the FSM restarts INIT_WAIT. The latched request is discarded.
- No error conditions; all opcode values map to a mnemonic.

Decomposition:
- mini_cpu_pkg holds:
  - opcode localparams (LOAD..DISPLAY)
  - LCD command constants: CMD_FUNC=8'h38, CMD_DISP_ON=8'h0C, CMD_CLEAR=8'h01, CMD_ENTRY=8'h06, CMD_LINE1=8'h80, CMD_LINE2=8'hC0
  - ASCII constants for '+', '-', space and '0'
  - FSM state enum
- One sub-module, bin16_to_bcd:
  - sequential double-dabble: 17-bit unsigned in, 5 BCD digits out
  - start/done handshake, done pulsed 1 cycle, 17 shift cycles
- Mnemonic lookup is a combinational function of the latched opcode and character index, kept in this module.

Test Plan (parameters INIT_WAIT_CYCLES=10, EN_CYCLES=2, WAIT_CYCLES=4, CLEAR_WAIT_CYCLES=8):
- Reset release:
  - Expect 10 idle cycles, then rs=0 writes of 0x38, 0x0C, 0x01, 0x06.
  - Each lcd_en pulse is exactly 2 cycles; the hold after 0x01 is 8 cycles.
  - req_ready rises only after the 0x06 hold.
- Request opcode=1 (ADD), result=16'd1234:
  - Writes: 0x80, "ADD" + 13 spaces, 0xC0, "+01234" + 10 spaces, all with rs=1 for chars.
  - Each write spans 7 cycles.
- Request opcode=3 (SUB), result=16'hFFFF: line 2 shows "-00001".
- Request opcode=5 (MUL), result=16'h8000: line 2 shows "-32768".
- Request opcode=7 (DISPLAY), result=16'h7FFF: line 1 shows "DISPLAY"; line 2 shows "+32767".
- Busy and reset:
  - Hold req_valid=1 continuously during a 34-write sequence: exactly one transfer per req_ready window.
  - Assert rst during WRITE_EN: lcd_en=0 on the next cycle, req_ready=0, and the init sequence replays from INIT_WAIT.
